// File: rtl/bus_pack_pkg.sv
// Shared defaults and FIFO entry layout for the 32->64 bit monitor-bus packer.
package bus_pack_pkg;

    localparam int unsigned IN_W  = 32;
    localparam int unsigned OUT_W = 64;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned CNT_W = 16;
    localparam int unsigned LVL_W = $clog2(DEPTH + 1);

    typedef struct packed {
        logic             partial;
        logic [OUT_W-1:0] data;
    } fifo_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Registered-storage synchronous FIFO with occupancy count; push and pop may coincide when full.
module sync_fifo #(
    parameter int unsigned W     = 65,
    parameter int unsigned DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_all,
    input  logic                         i_push,
    input  logic [W-1:0]                 i_push_data,
    input  logic                         i_pop,
    output logic                         o_full,
    output logic                         o_empty,
    output logic [$clog2(DEPTH+1)-1:0]   o_count,
    output logic [W-1:0]                 o_head
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [CW-1:0] r_count;

    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wptr] <= i_push_data;
        end
    end

    always_ff @(posedge clk or posedge rst_all) begin
        if (rst_all) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (i_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (i_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_head  = r_mem[r_rptr];

endmodule

// File: rtl/bus_word_packer.sv
// Packs pairs of 32-bit beats into 64-bit monitor-bus words, with zero-padded flush
// of a lone half-word and a small output FIFO; out_data reads zero while idle.
module bus_word_packer #(
    parameter int unsigned IN_W  = bus_pack_pkg::IN_W,
    parameter int unsigned OUT_W = bus_pack_pkg::OUT_W,
    parameter int unsigned DEPTH = bus_pack_pkg::DEPTH,
    parameter int unsigned CNT_W = bus_pack_pkg::CNT_W
) (
    input  logic                         clk,
    input  logic                         rst_all,
    input  logic [IN_W-1:0]              in_data,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic                         flush,
    output logic [OUT_W-1:0]             out_data,
    output logic                         out_partial,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [$clog2(DEPTH+1)-1:0]   level,
    output logic [CNT_W-1:0]             words_out
);

    import bus_pack_pkg::*;

    logic [IN_W-1:0]  r_half;
    logic             r_half_valid;
    logic             r_flush_pend;
    logic [CNT_W-1:0] r_words;

    logic        w_full;
    logic        w_empty;
    logic        w_pop;
    logic        w_space;
    logic        w_accept;
    logic        w_push;
    logic        w_half_load;
    logic        w_half_clr;
    logic        w_pend_set;
    logic        w_pend_clr;
    fifo_entry_t w_push_ent;
    fifo_entry_t w_head;

    assign w_pop    = !w_empty && out_ready;
    assign w_space  = !w_full || w_pop;
    assign in_ready = !r_flush_pend && (!r_half_valid || w_space);
    assign w_accept = in_valid && in_ready;

    always_comb begin
        w_push      = 1'b0;
        w_push_ent  = '0;
        w_half_load = 1'b0;
        w_half_clr  = 1'b0;
        w_pend_set  = 1'b0;
        w_pend_clr  = 1'b0;
        if (w_accept && r_half_valid) begin
            w_push          = 1'b1;
            w_push_ent.data = {in_data, r_half};
            w_half_clr      = 1'b1;
        end else if (w_accept) begin
            // A flushed lone beat goes straight out if there is room; otherwise it
            // parks in the half register and the pending flush pads it later.
            if (flush && w_space) begin
                w_push             = 1'b1;
                w_push_ent.partial = 1'b1;
                w_push_ent.data    = {{IN_W{1'b0}}, in_data};
            end else begin
                w_half_load = 1'b1;
                w_pend_set  = flush;
            end
        end else if (r_flush_pend || (flush && r_half_valid)) begin
            if (w_space) begin
                w_push             = 1'b1;
                w_push_ent.partial = 1'b1;
                w_push_ent.data    = {{IN_W{1'b0}}, r_half};
                w_half_clr         = 1'b1;
                w_pend_clr         = 1'b1;
            end else begin
                w_pend_set = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst_all) begin
        if (rst_all) begin
            r_half       <= '0;
            r_half_valid <= 1'b0;
            r_flush_pend <= 1'b0;
            r_words      <= '0;
        end else begin
            if (w_half_load) begin
                r_half       <= in_data;
                r_half_valid <= 1'b1;
            end else if (w_half_clr) begin
                r_half_valid <= 1'b0;
            end
            if (w_pend_set) begin
                r_flush_pend <= 1'b1;
            end else if (w_pend_clr) begin
                r_flush_pend <= 1'b0;
            end
            if (w_pop) begin
                r_words <= r_words + CNT_W'(1);
            end
        end
    end

    sync_fifo #(
        .W     ($bits(fifo_entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst_all     (rst_all),
        .i_push      (w_push),
        .i_push_data (w_push_ent),
        .i_pop       (w_pop),
        .o_full      (w_full),
        .o_empty     (w_empty),
        .o_count     (level),
        .o_head      (w_head)
    );

    assign out_valid   = !w_empty;
    assign out_data    = w_empty ? '0 : w_head.data;
    assign out_partial = w_empty ? 1'b0 : w_head.partial;
    assign words_out   = r_words;

endmodule

// File: tb/tb_bus_word_packer.sv
// Directed bench for bus_word_packer with a scoreboard of expected output words.
module tb_bus_word_packer;

    logic        clk = 1'b0;
    logic        rst_all;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic        flush;
    logic [63:0] out_data;
    logic        out_partial;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  level;
    logic [15:0] words_out;

    int checks   = 0;
    int failures = 0;
    logic [64:0] sb_q[$];

    always #5 clk = ~clk;

    bus_word_packer #(
        .IN_W  (32),
        .OUT_W (64),
        .DEPTH (4),
        .CNT_W (16)
    ) dut (
        .clk         (clk),
        .rst_all     (rst_all),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .flush       (flush),
        .out_data    (out_data),
        .out_partial (out_partial),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .level       (level),
        .words_out   (words_out)
    );

    task automatic check(input string tag, input logic [64:0] obs, input logic [64:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: called at a negedge with inputs already driven; returns at the next negedge.
    task automatic cycle(output bit acc);
        logic [64:0] exp;
        #1;
        acc = in_valid && in_ready;
        if (out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                check("sb_unexpected_pop", {out_partial, out_data}, 65'h0);
            end else begin
                exp = sb_q.pop_front();
                check("sb_word", {out_partial, out_data}, exp);
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic beat(input logic [31:0] d, input logic fl);
        bit acc;
        int n;
        in_data  = d;
        in_valid = 1'b1;
        flush    = fl;
        acc      = 1'b0;
        for (n = 0; n < 40 && !acc; n++) begin
            cycle(acc);
        end
        if (!acc) check("beat_accept_timeout", 65'(acc), 65'h1);
        in_valid = 1'b0;
        flush    = 1'b0;
    endtask

    task automatic drain();
        bit acc;
        out_ready = 1'b1;
        for (int n = 0; n < 40 && sb_q.size() != 0; n++) begin
            cycle(acc);
        end
        check("drain_sb_empty", 65'(sb_q.size()), 65'h0);
    endtask

    initial begin
        bit acc;
        rst_all   = 1'b1;
        in_data   = '0;
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_in_ready",    65'(in_ready),    65'h1);
        check("rst_out_valid",   65'(out_valid),   65'h0);
        check("rst_out_data",    65'(out_data),    65'h0);
        check("rst_out_partial", 65'(out_partial), 65'h0);
        check("rst_level",       65'(level),       65'h0);
        check("rst_words_out",   65'(words_out),   65'h0);
        rst_all = 1'b0;
        @(negedge clk);

        // Basic pair with one-cycle latency
        out_ready = 1'b1;
        sb_q.push_back({1'b0, 64'h12345678_0044ab93});
        beat(32'h0044ab93, 1'b0);
        check("half_no_valid", 65'(out_valid), 65'h0);
        beat(32'h12345678, 1'b0);
        check("pair_valid",   65'(out_valid),   65'h1);
        check("pair_data",    65'(out_data),    65'h12345678_0044ab93);
        check("pair_partial", 65'(out_partial), 65'h0);
        cycle(acc);
        check("pair_words_out", 65'(words_out), 65'h1);
        check("idle_out_data",  65'(out_data),  65'h0);
        check("idle_out_valid", 65'(out_valid), 65'h0);

        // Backpressure: fill FIFO, 9th beat to half, 10th held
        out_ready = 1'b0;
        for (int i = 1; i <= 9; i += 2) begin
            sb_q.push_back({1'b0, 32'(i + 1), 32'(i)});
        end
        for (int i = 1; i <= 8; i++) begin
            beat(32'(i), 1'b0);
        end
        check("full_level", 65'(level), 65'h4);
        beat(32'h9, 1'b0);
        in_data  = 32'hA;
        in_valid = 1'b1;
        #1;
        check("full_half_in_ready", 65'(in_ready), 65'h0);
        cycle(acc);
        check("held_not_taken_1", 65'(acc), 65'h0);
        cycle(acc);
        check("held_not_taken_2", 65'(acc), 65'h0);
        check("held_level", 65'(level), 65'h4);
        out_ready = 1'b1;
        #1;
        check("pop_opens_in_ready", 65'(in_ready), 65'h1);
        cycle(acc);
        check("held_taken_on_pop", 65'(acc), 65'h1);
        in_valid = 1'b0;
        check("push_pop_full_level", 65'(level), 65'h4);
        drain();
        check("bp_level_zero", 65'(level),     65'h0);
        check("bp_words_out",  65'(words_out), 65'h6);

        // Single beat then flush
        out_ready = 1'b0;
        sb_q.push_back({1'b1, 64'h00000000_DEADBEEF});
        beat(32'hDEADBEEF, 1'b0);
        flush = 1'b1;
        cycle(acc);
        flush = 1'b0;
        check("flush_valid",   65'(out_valid),   65'h1);
        check("flush_data",    65'(out_data),    65'h00000000_DEADBEEF);
        check("flush_partial", 65'(out_partial), 65'h1);
        check("flush_level",   65'(level),       65'h1);
        drain();
        check("flush_words_out", 65'(words_out), 65'h7);

        // Flush with full FIFO and pending half -> flush_pend
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            sb_q.push_back({1'b0, 32'h20 + 32'(2 * i + 1), 32'h20 + 32'(2 * i)});
        end
        sb_q.push_back({1'b1, 64'h00000000_000000FF});
        for (int i = 0; i < 8; i++) begin
            beat(32'h20 + 32'(i), 1'b0);
        end
        beat(32'hFF, 1'b0);
        flush = 1'b1;
        cycle(acc);
        flush = 1'b0;
        #1;
        check("pend_in_ready_0", 65'(in_ready), 65'h0);
        cycle(acc);
        check("pend_level", 65'(level), 65'h4);
        out_ready = 1'b1;
        #1;
        check("pend_blocks_with_pop", 65'(in_ready), 65'h0);
        cycle(acc);
        out_ready = 1'b0;
        check("pend_push_on_pop_level", 65'(level),    65'h4);
        check("pend_cleared_in_ready",  65'(in_ready), 65'h1);
        drain();
        check("pend_words_out", 65'(words_out), 65'd12);

        // Async reset with level=3 and half pending
        out_ready = 1'b0;
        for (int i = 0; i < 7; i++) begin
            beat(32'hC0 + 32'(i), 1'b0);
        end
        check("pre_rst_level", 65'(level), 65'h3);
        #2;
        rst_all = 1'b1;
        #1;
        check("arst_out_valid", 65'(out_valid), 65'h0);
        check("arst_level",     65'(level),     65'h0);
        check("arst_words_out", 65'(words_out), 65'h0);
        check("arst_out_data",  65'(out_data),  65'h0);
        sb_q.delete();
        @(negedge clk);
        rst_all = 1'b0;
        @(negedge clk);
        sb_q.push_back({1'b0, 64'h5555BBBB_4444AAAA});
        beat(32'h4444AAAA, 1'b0);
        beat(32'h5555BBBB, 1'b0);
        check("post_rst_data",  65'(out_data), 65'h5555BBBB_4444AAAA);
        check("post_rst_level", 65'(level),    65'h1);
        drain();
        check("post_rst_words_out", 65'(words_out), 65'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/bus_word_packer.md
Name: bus_word_packer

Overview:
- Packs the accelerator's 32-bit memory/instruction traffic into 64-bit words for the 64-bit monitor bus that feeds the downstream key-capture/observation stage.
- First 32-bit beat fills bits [31:0]; second beat fills [63:32].
- Completed words are buffered in a small FIFO and presented with a valid/ready handshake.
- The output reads as all-zero when idle, so the downstream stage never samples stale data.

Parameters:
- IN_W, 32, input beat width; OUT_W must equal 2*IN_W.
- OUT_W, 64, packed output word width.
- DEPTH, 4, FIFO depth in OUT_W words; power of two, at least 2.
- CNT_W, 16, width of the emitted-word counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_all  in  1  asynchronous, active-high reset; clears all state.
- in_data  in  IN_W  input beat.
- in_valid  in  1  in_data is valid this cycle.
- in_ready  out  1  packer accepts the beat this cycle.
- flush  in  1  single-cycle pulse: emit any pending half-word, zero-padded.
- out_data  out  OUT_W  FIFO head word; 0 when out_valid=0.
- out_partial  out  1  head word was produced by flush (upper half padded).
- out_valid  out  1  FIFO not empty.
- out_ready  in  1  consumer takes the head word this cycle.
- level  out  $clog2(DEPTH+1)  FIFO occupancy.
- words_out  out  CNT_W  count of words popped; wraps modulo 2^CNT_W.

Behaviour:
- Reset values: in_ready=1, out_valid=0, out_data=0, out_partial=0, level=0, words_out=0.
  - Reset also clears the half register, half_valid, flush_pend, and FIFO pointers.
- Reset asserted mid-operation discards pending half and all buffered words immediately.
- Accept: beat accepted when in_valid && in_ready.
- Half register: with half_valid=0, an accepted beat goes to half, and half_valid is set.
  - With half_valid=1, an accepted beat forms {in_data, half}, pushed with partial=0; half_valid is cleared.
- in_ready rules:
  - in_ready = !flush_pend && (!half_valid || !full || pop).
  - pop = out_valid && out_ready.
  - A combinational path from out_ready to in_ready is permitted.
- Push/pop in the same cycle with FIFO full is legal; occupancy is unchanged.
- Latency: the word completed by the second accepted beat appears at out_data on the next cycle if FIFO was empty.
- out_data/out_partial are driven from the FIFO head, gated to 0 when empty.
- Flush:
  - flush with half_valid=0 and no beat accepted: no-op.
  - flush with half_valid=1: push {0, half} with partial=1, clear half_valid.
  - flush in the same cycle as an accepted beat:
    - If the beat completes a pair, the pair is pushed normally and flush is a no-op.
    - If the beat lands in an empty half, push {0, in_data} with partial=1 in that cycle, subject to space.
  - If the FIFO is full (and no pop) when a flush push is due, set flush_pend.
    - in_ready stays 0 while flush_pend=1.
    - The padded push happens on the first cycle with space; then flush_pend clears.
- flush while flush_pend=1 is ignored.
- words_out increments on every pop and wraps silently.
- level always equals pushes minus pops since reset; it never exceeds DEPTH.
- in_valid with in_ready=0: beat not taken; the source must hold it (standard valid/ready).

Decomposition:
- Package bus_pack_pkg:
  - IN_W, OUT_W, DEPTH defaults.
  - FIFO entry struct {partial, data[OUT_W-1:0]}.
  - Localparam for the level width.
- Sub-module sync_fifo (DEPTH x OUT_W+1, registered storage):
  - Outputs: full, empty, count, head.
  - Inputs: push/pop.
  - Async active-high reset on rst_all.
- Packing, flush and pend logic stay in bus_word_packer.

Test Plan:
- Reset then beats 0x0044ab93, 0x12345678 with out_ready=1 -> next cycle out_data=0x123456780044ab93, out_partial=0, out_valid=1; one cycle later words_out=1 and out_data=0.
- out_ready=0, stream 10 beats -> after 8 beats level=4; in_ready=0 with half_valid=1; the 9th beat (0x9) is taken into half; the 10th beat (0xA) is held, no data lost.
- Release out_ready=1 in that state -> words popped in order with beat pairs intact; the held beat is accepted on the first pop cycle.
- Single beat 0xDEADBEEF then flush -> out_data=0x00000000DEADBEEF, out_partial=1.
- Flush with FIFO full and half pending -> flush_pend=1, in_ready=0 until one pop; the padded word is pushed on the pop cycle and in_ready returns to 1 next cycle.
- Assert rst_all asynchronously (mid-clock) with level=3 and half_valid=1 -> out_valid, level and words_out go to 0 without waiting for a clock edge.
  - The next two beats form a fresh word containing no old data.
